// File: rtl/spi_slave_mailbox_pkg.sv
// Shared constants for the SPI slave mailbox.
// Register numbers, idle byte and status bit layout.
package spi_slave_mailbox_pkg;

  localparam logic [7:0] REG_DATA_DEF  = 8'hC6;
  localparam logic [7:0] REG_STAT_DEF  = 8'hC7;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

  localparam int ST_RX_NE    = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_TX_UND   = 3;
  localparam int ST_CS_ACT   = 4;
  localparam int ST_ABORT    = 5;

  typedef struct packed {
    logic abort;
    logic underrun;
    logic overrun;
  } sticky_t;

endpackage

// File: rtl/spi_slave_rxfifo.sv
// Small synchronous FIFO for received SPI bytes.
// Full/empty told apart by an extra pointer bit.
module spi_slave_rxfifo #(
  parameter int AW = 2,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_pop;
  logic         do_push;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // A pop on a full FIFO frees the slot a same-cycle push needs
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

  assign head = mem[rp[AW-1:0]];

endmodule

// File: rtl/spi_slave_mailbox.sv
// SPI mode-0 responder exchanging bytes with the CPU
// through two ZXUNO registers; SPI pins oversampled in clk.
module spi_slave_mailbox
  import spi_slave_mailbox_pkg::*;
#(
  parameter logic [7:0] REG_DATA     = REG_DATA_DEF,
  parameter logic [7:0] REG_STAT     = REG_STAT_DEF,
  parameter int         RXDEPTH_LOG2 = 2,
  parameter logic [7:0] IDLE_BYTE    = IDLE_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic       ior,
  input  logic       iow,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe,
  output logic       irq,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  logic       cs_s1, cs_s2, cs_q;
  logic       sck_s1, sck_s2, sck_q;
  logic       mosi_s1, mosi_s2;
  logic [1:0] warm;
  logic       armed;
  logic       in_frame;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [6:0] tx_shift;
  logic [7:0] tx_hold;
  logic       tx_valid;
  sticky_t    st;
  logic       ior_q, iow_q;

  logic       cs_fall, cs_rise;
  logic       sck_rise, sck_fall;
  logic       reload;
  logic [7:0] next_tx;
  logic [7:0] rx_byte;
  logic       push, pop;
  logic [7:0] head;
  logic       empty, full;
  logic       tx_wr, st_wr;
  logic [7:0] stat;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_q    <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      warm    <= 2'd0;
      armed   <= 1'b0;
    end else begin
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      cs_q    <= cs_s2;
      sck_s1  <= spi_sclk;
      sck_s2  <= sck_s1;
      sck_q   <= sck_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
      if (warm != 2'd2) warm <= warm + 2'd1;
      // A frame cut by reset is ignored until CS is seen high
      armed   <= armed | ((warm == 2'd2) & cs_s2);
    end
  end

  assign cs_fall  = armed & cs_q & ~cs_s2;
  assign cs_rise  = in_frame & cs_s2;
  assign sck_rise = in_frame & ~cs_s2 & sck_s2 & ~sck_q;
  assign sck_fall = in_frame & ~cs_s2 & ~sck_s2 & sck_q;
  assign reload   = cs_fall | (sck_fall & (bit_cnt == 3'd0));
  assign next_tx  = tx_valid ? tx_hold : IDLE_BYTE;
  assign rx_byte  = {rx_shift, mosi_s2};
  assign push     = sck_rise & (bit_cnt == 3'd7);
  assign pop      = ior_q & ~ior & (addr == REG_DATA);
  assign tx_wr    = iow & ~iow_q & (addr == REG_DATA);
  assign st_wr    = iow & ~iow_q & (addr == REG_STAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame    <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_shift    <= 7'd0;
      tx_shift    <= IDLE_BYTE[6:0];
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
    end else if (cs_s2) begin
      in_frame    <= 1'b0;
      bit_cnt     <= 3'd0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
    end else if (cs_fall) begin
      in_frame    <= 1'b1;
      bit_cnt     <= 3'd0;
      tx_shift    <= next_tx[6:0];
      spi_miso    <= next_tx[7];
      spi_miso_oe <= 1'b1;
    end else if (in_frame) begin
      if (sck_rise) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (sck_fall) begin
        if (bit_cnt != 3'd0) begin
          spi_miso <= tx_shift[6];
          tx_shift <= {tx_shift[5:0], 1'b1};
        end else begin
          spi_miso <= next_tx[7];
          tx_shift <= next_tx[6:0];
        end
      end
    end
  end

  // Later assignments win: CPU load beats reload, sticky set beats W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_hold  <= IDLE_BYTE;
      tx_valid <= 1'b0;
      st       <= '0;
      ior_q    <= 1'b0;
      iow_q    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ior_q <= ior;
      iow_q <= iow;
      irq   <= ~empty;
      if (reload) tx_valid <= 1'b0;
      if (tx_wr) begin
        tx_hold  <= din;
        tx_valid <= 1'b1;
      end
      if (st_wr) begin
        if (din[ST_ABORT])  st.abort    <= 1'b0;
        if (din[ST_TX_UND]) st.underrun <= 1'b0;
        if (din[ST_RX_OVR]) st.overrun  <= 1'b0;
      end
      if (cs_rise && bit_cnt != 3'd0) st.abort <= 1'b1;
      if (reload && !tx_valid) st.underrun <= 1'b1;
      if (push && full && !pop) st.overrun <= 1'b1;
    end
  end

  spi_slave_rxfifo #(
    .AW (RXDEPTH_LOG2),
    .W  (8)
  ) u_rxfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rx_byte),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  assign stat = {2'b00, st.abort, in_frame, st.underrun,
                 st.overrun, ~tx_valid, ~empty};

  always_comb begin
    oe   = 1'b0;
    dout = 8'hFF;
    if (ior && addr == REG_DATA) begin
      oe   = 1'b1;
      dout = empty ? 8'hFF : head;
    end else if (ior && addr == REG_STAT) begin
      oe   = 1'b1;
      dout = stat;
    end
  end

endmodule

// File: tb/tb_spi_slave_mailbox.sv
// Bench for spi_slave_mailbox: SPI master model plus
// a queue-based reference of the mailbox behaviour.
module tb_spi_slave_mailbox;

  localparam logic [7:0] RD = 8'hC6;
  localparam logic [7:0] RS = 8'hC7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'h00;
  logic       ior = 1'b0;
  logic       iow = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe;
  logic       irq;
  logic       spi_cs_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] m_q[$];
  logic       m_txv;
  logic [7:0] m_hold;
  logic       m_ovr, m_und, m_abort;
  logic [7:0] m_cur;

  spi_slave_mailbox dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .ior         (ior),
    .iow         (iow),
    .din         (din),
    .dout        (dout),
    .oe          (oe),
    .irq         (irq),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_reset();
    m_q.delete();
    m_txv = 1'b0;
    m_hold = 8'hFF;
    m_ovr = 1'b0;
    m_und = 1'b0;
    m_abort = 1'b0;
  endtask

  // Every byte slot takes the held byte if present, else idle
  task automatic m_load();
    if (m_txv) m_cur = m_hold;
    else begin
      m_cur = 8'hFF;
      m_und = 1'b1;
    end
    m_txv = 1'b0;
  endtask

  function automatic logic [7:0] m_stat();
    return {2'b00, m_abort, 1'b0, m_und, m_ovr,
            ~m_txv, (m_q.size() != 0)};
  endfunction

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    din = d;
    iow = 1'b1;
    wait_clk(2);
    iow = 1'b0;
    wait_clk(2);
    if (a == RD) begin
      m_hold = d;
      m_txv = 1'b1;
    end else if (a == RS) begin
      if (d[2]) m_ovr = 1'b0;
      if (d[3]) m_und = 1'b0;
      if (d[5]) m_abort = 1'b0;
    end
  endtask

  task automatic cpu_read(input logic [7:0] a, input int hold,
                          output logic [7:0] d, output logic o);
    addr = a;
    ior = 1'b1;
    wait_clk(hold);
    d = dout;
    o = oe;
    ior = 1'b0;
    wait_clk(3);
    addr = 8'h00;
  endtask

  function automatic logic [7:0] m_pop();
    if (m_q.size() == 0) return 8'hFF;
    return m_q.pop_front();
  endfunction

  task automatic spi_bits(input logic [7:0] mo, input int nbits,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      wait_clk(8);
      mi[7-i] = spi_miso;
      spi_sclk = 1'b1;
      wait_clk(8);
      spi_sclk = 1'b0;
    end
    wait_clk(8);
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    m_load();
    wait_clk(8);
  endtask

  task automatic cs_end();
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic xfer(input logic [7:0] mo, output logic [7:0] mi,
                      output logic [7:0] exp);
    exp = m_cur;
    spi_bits(mo, 8, mi);
    if (m_q.size() < 4) m_q.push_back(mo);
    else m_ovr = 1'b1;
    m_load();
  endtask

  task automatic chk8(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic o;
    checks++;
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b1) begin
      errors++;
      $display("FAIL reset_miso: got oe=%b miso=%b expected 0 1",
               spi_miso_oe, spi_miso);
    end
    checks++;
    if (irq !== 1'b0 || oe !== 1'b0 || dout !== 8'hFF) begin
      errors++;
      $display("FAIL reset_cpu: got irq=%b oe=%b dout=%h expected 0 0 ff",
               irq, oe, dout);
    end
    cpu_read(RS, 2, d, o);
    checks++;
    if (d !== m_stat() || o !== 1'b1) begin
      errors++;
      $display("FAIL reset_stat: got %h oe=%b expected %h oe=1",
               d, o, m_stat());
    end
    cpu_read(8'h10, 2, d, o);
    checks++;
    if (d !== 8'hFF || o !== 1'b0) begin
      errors++;
      $display("FAIL other_addr: got %h oe=%b expected ff oe=0", d, o);
    end
  endtask

  task automatic test_basic();
    logic [7:0] mi, exp, d;
    logic o;
    cpu_write(RD, 8'hA5);
    cs_begin();
    checks++;
    if (spi_miso_oe !== 1'b1) begin
      errors++;
      $display("FAIL basic_miso_oe: got %b expected 1", spi_miso_oe);
    end
    xfer(8'h3C, mi, exp);
    chk8("basic_miso", mi, exp);
    cs_end();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL basic_irq_set: got %b expected 1", irq);
    end
    cpu_read(RD, 2, d, o);
    chk8("basic_rx", d, m_pop());
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL basic_irq_clr: got %b expected 0", irq);
    end
    cpu_read(RS, 2, d, o);
    chk8("basic_stat", d, m_stat());
    cpu_write(RS, 8'h2C);
  endtask

  task automatic test_underrun();
    logic [7:0] mi, exp, d;
    logic o;
    cs_begin();
    for (int i = 0; i < 3; i++) begin
      xfer(8'h50 + 8'(i), mi, exp);
      chk8("underrun_miso", mi, exp);
    end
    cs_end();
    cpu_read(RS, 2, d, o);
    chk8("underrun_stat", d, m_stat());
    cpu_write(RS, 8'h08);
    cpu_read(RS, 2, d, o);
    chk8("underrun_clr", d, m_stat());
    for (int i = 0; i < 3; i++) begin
      cpu_read(RD, 2, d, o);
      chk8("underrun_rx", d, m_pop());
    end
  endtask

  task automatic test_overrun();
    logic [7:0] mi, exp, d;
    logic o;
    cs_begin();
    for (int i = 1; i <= 5; i++) xfer(8'(i), mi, exp);
    cs_end();
    cpu_read(RS, 2, d, o);
    chk8("overrun_stat", d, m_stat());
    for (int i = 0; i < 5; i++) begin
      cpu_read(RD, 2, d, o);
      chk8("overrun_rx", d, m_pop());
    end
    cpu_write(RS, 8'h2C);
  endtask

  task automatic test_abort();
    logic [7:0] mi, exp, d;
    logic o;
    cs_begin();
    spi_bits(8'hE7, 5, mi);
    cs_end();
    m_abort = 1'b1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL abort_irq: got %b expected 0", irq);
    end
    cpu_read(RS, 2, d, o);
    chk8("abort_stat", d, m_stat());
    cs_begin();
    xfer(8'h81, mi, exp);
    cs_end();
    cpu_read(RD, 2, d, o);
    chk8("abort_next_rx", d, m_pop());
    cpu_write(RS, 8'h2C);
  endtask

  task automatic test_long_read();
    logic [7:0] mi, exp, d;
    logic o;
    cs_begin();
    xfer(8'h11, mi, exp);
    xfer(8'h22, mi, exp);
    cs_end();
    cpu_read(RD, 6, d, o);
    chk8("long_read_first", d, m_pop());
    cpu_read(RD, 2, d, o);
    chk8("long_read_second", d, m_pop());
    cpu_read(RD, 2, d, o);
    chk8("long_read_empty", d, m_pop());
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi, exp, d;
    logic o;
    cpu_write(RD, 8'h77);
    cs_begin();
    spi_bits(8'hAA, 4, mi);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    m_reset();
    checks++;
    if (spi_miso_oe !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_out: got oe=%b irq=%b expected 0 0",
               spi_miso_oe, irq);
    end
    cpu_read(RS, 2, d, o);
    chk8("rst_mid_stat", d, 8'h02);
    spi_bits(8'hAA, 4, mi);
    cs_end();
    cpu_read(RD, 2, d, o);
    chk8("rst_mid_empty", d, m_pop());
    cpu_write(RD, 8'h5A);
    cs_begin();
    xfer(8'h42, mi, exp);
    chk8("rst_mid_miso", mi, exp);
    cs_end();
    cpu_read(RD, 2, d, o);
    chk8("rst_mid_rx", d, m_pop());
  endtask

  task automatic test_random();
    logic [7:0] mi, exp, d;
    logic o;
    int nb, nr;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(1, 0) == 1)
        cpu_write(RD, 8'($urandom));
      if ($urandom_range(3, 0) == 0)
        cpu_write(RS, 8'($urandom));
      nb = int'($urandom_range(3, 1));
      cs_begin();
      for (int b = 0; b < nb; b++) begin
        xfer(8'($urandom), mi, exp);
        chk8("rand_miso", mi, exp);
      end
      cs_end();
      cpu_read(RS, 2, d, o);
      chk8("rand_stat", d, m_stat());
      nr = int'($urandom_range(3, 0));
      for (int r = 0; r < nr; r++) begin
        cpu_read(RD, int'($urandom_range(4, 1)), d, o);
        chk8("rand_rx", d, m_pop());
      end
    end
  endtask

  initial begin
    m_reset();
    m_cur = 8'hFF;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(8);
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_abort();
    test_long_read();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
